// File: rtl/dcache_controller.sv
// dcache_controller
//   Control FSM for a write-back data cache with line-sized transfers to L2.
//   Hits complete in the same cycle they are presented. Misses optionally
//   write back a dirty victim, then allocate the new line word by word. The
//   held request is then re-evaluated and completes as a hit.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   pipe_req_valid/_type        pipeline request (0 LOAD, 1 STORE, 2 CLFLUSH, 3 reserved)
//   pipe_req_fulfilled          request completes this cycle
//   l2_req_valid/_type          word request to L2 (type 0 LOAD, 1 STORE)
//   l2_req_fulfilled            L2 finished the current word
//   counter_done                word counter at its last word
//   valid_block_match           selected line is valid and its tag matches
//   valid_dirty_bit             selected line is valid and dirty
//   datapath strobes            mode selects, metadata set/clear, write enable,
//                               L2 address load, word counter control
//   hit_count/miss_count        saturating statistics
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | evaluate the pipeline request against the selected line
// WRITEBACK | stream the dirty victim line to L2, one word per handshake
// ALLOCATE  | stream the requested line from L2 into the data array

module dcache_controller #(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_req_valid,
  input  logic [1:0]            pipe_req_type,
  output logic                  pipe_req_fulfilled,
  output logic                  l2_req_valid,
  output logic                  l2_req_type,
  input  logic                  l2_req_fulfilled,
  input  logic                  counter_done,
  input  logic                  valid_block_match,
  input  logic                  valid_dirty_bit,
  output logic                  flush_mode,
  output logic                  load_mode,
  output logic                  clear_selected_dirty_bit,
  output logic                  set_selected_dirty_bit,
  output logic                  perform_write,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  set_new_l2_block_address,
  output logic                  use_dirty_tag_for_l2_block_address,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  localparam logic [1:0] REQ_LOAD    = 2'd0;
  localparam logic [1:0] REQ_STORE   = 2'd1;
  localparam logic [1:0] REQ_CLFLUSH = 2'd2;

  localparam logic L2_LOAD  = 1'b0;
  localparam logic L2_STORE = 1'b1;

  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [STAT_WIDTH-1:0] r_hit_count;
  logic [STAT_WIDTH-1:0] r_miss_count;
  // Set when a line install finishes, so the re-evaluated request that then
  // hits in IDLE is not counted a second time as a hit.
  logic                  r_from_alloc;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_alloc_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_from_alloc <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_hit_inc && (r_hit_count != STAT_MAX))
        r_hit_count <= r_hit_count + STAT_ONE;
      if (w_miss_inc && (r_miss_count != STAT_MAX))
        r_miss_count <= r_miss_count + STAT_ONE;
      if (w_alloc_done)
        r_from_alloc <= 1'b1;
      else if (pipe_req_fulfilled)
        r_from_alloc <= 1'b0;
    end
  end

  always_comb begin
    w_next_state                       = r_state;
    w_hit_inc                          = 1'b0;
    w_miss_inc                         = 1'b0;
    w_alloc_done                       = 1'b0;
    pipe_req_fulfilled                 = 1'b0;
    l2_req_valid                       = 1'b0;
    l2_req_type                        = L2_LOAD;
    flush_mode                         = 1'b0;
    load_mode                          = 1'b0;
    clear_selected_dirty_bit           = 1'b0;
    set_selected_dirty_bit             = 1'b0;
    perform_write                      = 1'b0;
    clear_selected_valid_bit           = 1'b0;
    finish_new_line_install            = 1'b0;
    set_new_l2_block_address           = 1'b0;
    use_dirty_tag_for_l2_block_address = 1'b0;
    reset_counter                      = 1'b0;
    decrement_counter                  = 1'b0;

    // Outputs are held at zero for the whole reset cycle, whatever the state.
    if (!reset) begin
      unique case (r_state)
        ST_IDLE: begin
          if (pipe_req_valid) begin
            case (pipe_req_type)
              REQ_LOAD, REQ_STORE: begin
                if (valid_block_match) begin
                  pipe_req_fulfilled = 1'b1;
                  w_hit_inc          = !r_from_alloc;
                  if (pipe_req_type == REQ_STORE) begin
                    perform_write          = 1'b1;
                    set_selected_dirty_bit = 1'b1;
                  end
                end else begin
                  set_new_l2_block_address = 1'b1;
                  reset_counter            = 1'b1;
                  w_miss_inc               = 1'b1;
                  if (valid_dirty_bit) begin
                    use_dirty_tag_for_l2_block_address = 1'b1;
                    w_next_state                       = ST_WRITEBACK;
                  end else begin
                    clear_selected_valid_bit = 1'b1;
                    w_next_state             = ST_ALLOCATE;
                  end
                end
              end
              REQ_CLFLUSH: begin
                if (!valid_block_match) begin
                  pipe_req_fulfilled = 1'b1;
                end else if (!valid_dirty_bit) begin
                  clear_selected_valid_bit = 1'b1;
                  pipe_req_fulfilled       = 1'b1;
                end else begin
                  set_new_l2_block_address           = 1'b1;
                  use_dirty_tag_for_l2_block_address = 1'b1;
                  reset_counter                      = 1'b1;
                  w_next_state                       = ST_WRITEBACK;
                end
              end
              default: begin
                pipe_req_fulfilled = 1'b1;
              end
            endcase
          end
        end

        ST_WRITEBACK: begin
          flush_mode   = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = L2_STORE;
          if (l2_req_fulfilled) begin
            if (!counter_done) begin
              decrement_counter = 1'b1;
            end else begin
              clear_selected_dirty_bit = 1'b1;
              if (pipe_req_type == REQ_CLFLUSH) begin
                clear_selected_valid_bit = 1'b1;
                pipe_req_fulfilled       = 1'b1;
                w_next_state             = ST_IDLE;
              end else begin
                // Victim is out; point L2 at the requested line and refill.
                set_new_l2_block_address = 1'b1;
                reset_counter            = 1'b1;
                clear_selected_valid_bit = 1'b1;
                w_next_state             = ST_ALLOCATE;
              end
            end
          end
        end

        ST_ALLOCATE: begin
          load_mode    = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = L2_LOAD;
          if (l2_req_fulfilled) begin
            perform_write = 1'b1;
            if (!counter_done) begin
              decrement_counter = 1'b1;
            end else begin
              finish_new_line_install = 1'b1;
              w_alloc_done            = 1'b1;
              w_next_state            = ST_IDLE;
            end
          end
        end

        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign hit_count  = reset ? '0 : r_hit_count;
  assign miss_count = reset ? '0 : r_miss_count;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller with a one-line datapath/L2 model around it.
// A reference model predicts, per request, the L2 traffic, the strobes in the
// completing cycle and the statistics; a monitor pops those predictions when
// the DUT fulfils a request.

module tb_dcache_controller;

  localparam int SW      = 4;
  localparam int WORDS   = 8;
  localparam int STATMAX = (1 << SW) - 1;

  logic          clk;
  logic          reset;
  logic          pipe_req_valid;
  logic [1:0]    pipe_req_type;
  logic          pipe_req_fulfilled;
  logic          l2_req_valid;
  logic          l2_req_type;
  logic          l2_req_fulfilled;
  logic          counter_done;
  logic          valid_block_match;
  logic          valid_dirty_bit;
  logic          flush_mode;
  logic          load_mode;
  logic          clear_selected_dirty_bit;
  logic          set_selected_dirty_bit;
  logic          perform_write;
  logic          clear_selected_valid_bit;
  logic          finish_new_line_install;
  logic          set_new_l2_block_address;
  logic          use_dirty_tag_for_l2_block_address;
  logic          reset_counter;
  logic          decrement_counter;
  logic [SW-1:0] hit_count;
  logic [SW-1:0] miss_count;

  dcache_controller #(.STAT_WIDTH(SW)) dut (
    .clk                                (clk),
    .reset                              (reset),
    .pipe_req_valid                     (pipe_req_valid),
    .pipe_req_type                      (pipe_req_type),
    .pipe_req_fulfilled                 (pipe_req_fulfilled),
    .l2_req_valid                       (l2_req_valid),
    .l2_req_type                        (l2_req_type),
    .l2_req_fulfilled                   (l2_req_fulfilled),
    .counter_done                       (counter_done),
    .valid_block_match                  (valid_block_match),
    .valid_dirty_bit                    (valid_dirty_bit),
    .flush_mode                         (flush_mode),
    .load_mode                          (load_mode),
    .clear_selected_dirty_bit           (clear_selected_dirty_bit),
    .set_selected_dirty_bit             (set_selected_dirty_bit),
    .perform_write                      (perform_write),
    .clear_selected_valid_bit           (clear_selected_valid_bit),
    .finish_new_line_install            (finish_new_line_install),
    .set_new_l2_block_address           (set_new_l2_block_address),
    .use_dirty_tag_for_l2_block_address (use_dirty_tag_for_l2_block_address),
    .reset_counter                      (reset_counter),
    .decrement_counter                  (decrement_counter),
    .hit_count                          (hit_count),
    .miss_count                         (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int typ;
    int wb;
    int ld;
    int pw;
    int inst;
    int addr;
    int dtag;
    int f_pw;
    int f_sd;
    int f_cd;
    int f_cv;
    int hit;
    int miss;
  } exp_t;

  exp_t sb_q[$];

  // reference view of the single cache line and of the statistics
  int ref_v = 0, ref_d = 0, ref_t = 0;
  int ref_hit = 0, ref_miss = 0;

  // datapath/L2 model state, driven purely by DUT strobes
  int req_tag  = 0;
  int dp_v     = 0, dp_d = 0, dp_t = 0, dp_cnt = 0;
  int l2_w     = 0;
  int l2_lat   = 2;
  int rand_lat = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic int sat(input int x);
    return (x > STATMAX) ? STATMAX : x;
  endfunction

  task automatic check_all_zero(input string name);
    logic [13:0] v;
    v = {pipe_req_fulfilled, l2_req_valid, l2_req_type, flush_mode, load_mode,
         clear_selected_dirty_bit, set_selected_dirty_bit, perform_write,
         clear_selected_valid_bit, finish_new_line_install,
         set_new_l2_block_address, use_dirty_tag_for_l2_block_address,
         reset_counter, decrement_counter};
    check({name, " outputs"}, int'(v), 0);
    check({name, " hit_count"}, int'(hit_count), 0);
    check({name, " miss_count"}, int'(miss_count), 0);
  endtask

  // Datapath + L2 model: observe strobes mid-cycle, apply their effect after
  // the next rising edge (after the stimulus has updated the request).
  initial begin
    int nf;
    l2_req_fulfilled  = 1'b0;
    counter_done      = 1'b0;
    valid_block_match = 1'b0;
    valid_dirty_bit   = 1'b0;
    forever begin
      @(negedge clk);
      nf = 0;
      if (reset) begin
        l2_w = 0;
      end else begin
        if (clear_selected_valid_bit) dp_v = 0;
        if (set_selected_dirty_bit)   dp_d = 1;
        if (clear_selected_dirty_bit) dp_d = 0;
        if (finish_new_line_install) begin
          dp_v = 1;
          dp_t = req_tag;
          dp_d = 0;
        end
        if (reset_counter)          dp_cnt = WORDS - 1;
        else if (decrement_counter) dp_cnt = dp_cnt - 1;
        if (l2_req_fulfilled) begin
          l2_w = 0;
          if (rand_lat != 0) l2_lat = $urandom_range(1, 3);
        end else if (l2_req_valid) begin
          l2_w = l2_w + 1;
          nf   = (l2_w >= l2_lat) ? 1 : 0;
        end
      end
      @(posedge clk);
      #2;
      l2_req_fulfilled  = (nf != 0);
      counter_done      = (dp_cnt == 0);
      valid_block_match = (dp_v != 0) && (dp_t == req_tag);
      valid_dirty_bit   = (dp_v != 0) && (dp_d != 0);
    end
  end

  // Predict the whole transaction from the reference line, queue it, then
  // present the request and hold it until fulfilled.
  task automatic issue(input int typ, input int tag);
    exp_t e;
    int   hit;
    int   dvict;
    int   done;
    logic [31:0] t32;
    hit   = (ref_v != 0 && ref_t == tag) ? 1 : 0;
    dvict = (ref_v != 0 && ref_d != 0) ? 1 : 0;
    e = '{default: 0};
    e.typ = typ;
    if (typ == 0 || typ == 1) begin
      e.f_pw = (typ == 1) ? 1 : 0;
      e.f_sd = e.f_pw;
      if (hit != 0) begin
        e.pw    = e.f_pw;
        ref_hit = sat(ref_hit + 1);
        if (typ == 1) ref_d = 1;
      end else begin
        e.wb     = dvict * WORDS;
        e.ld     = WORDS;
        e.pw     = WORDS + e.f_pw;
        e.inst   = 1;
        e.addr   = 1 + dvict;
        e.dtag   = dvict;
        ref_miss = sat(ref_miss + 1);
        ref_v    = 1;
        ref_t    = tag;
        ref_d    = (typ == 1) ? 1 : 0;
      end
    end else if (typ == 2 && hit != 0) begin
      e.f_cv = 1;
      if (ref_d != 0) begin
        e.wb   = WORDS;
        e.addr = 1;
        e.dtag = 1;
        e.f_cd = 1;
      end
      ref_v = 0;
      ref_d = 0;
    end
    e.hit  = ref_hit;
    e.miss = ref_miss;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    t32            = typ;
    req_tag        = tag;
    pipe_req_type  = t32[1:0];
    pipe_req_valid = 1'b1;
    done = 0;
    for (int n = 0; n < 400 && done == 0; n++) begin
      @(negedge clk);
      done = pipe_req_fulfilled ? 1 : 0;
    end
    checks++;
    if (done == 0) begin
      errors++;
      $display("FAIL request timeout: type %0d tag %0d not fulfilled in 400 cycles", typ, tag);
      finish_run();
    end
  endtask

  // Monitor: per-transaction accumulation, scoreboard pop on fulfil,
  // statistics compared one cycle later, plus per-cycle invariants.
  initial begin
    int   wb, ld, pw, inst, addr, dtag, pend;
    int   p_l2v, p_l2f, p_l2t, p_ful;
    exp_t e;
    exp_t pe;
    wb = 0; ld = 0; pw = 0; inst = 0; addr = 0; dtag = 0; pend = 0;
    p_l2v = 0; p_l2f = 0; p_l2t = 0; p_ful = 0;
    pe = '{default: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        wb = 0; ld = 0; pw = 0; inst = 0; addr = 0; dtag = 0; pend = 0;
        p_l2v = 0; p_l2f = 0; p_l2t = 0; p_ful = 0;
        continue;
      end
      if (pend != 0) begin
        check("hit_count", int'(hit_count), pe.hit);
        check("miss_count", int'(miss_count), pe.miss);
        pend = 0;
      end
      if (set_selected_dirty_bit && clear_selected_dirty_bit)
        check("dirty set/clear exclusive", 1, 0);
      if (finish_new_line_install && clear_selected_valid_bit)
        check("valid set/clear exclusive", 1, 0);
      if (flush_mode || load_mode)
        check("flush/load mode exclusive", int'(flush_mode && load_mode), 0);
      if (flush_mode)
        check("flush_mode with L2 store", int'(l2_req_valid && l2_req_type), 1);
      if (load_mode)
        check("load_mode with L2 load", int'(l2_req_valid && !l2_req_type), 1);
      if (p_l2v != 0 && p_l2f == 0) begin
        check("l2_req_valid held", int'(l2_req_valid), 1);
        check("l2_req_type held", int'(l2_req_type), p_l2t);
      end
      assert (!(p_l2v != 0 && p_ful == 0 && !pipe_req_valid))
        else $error("protocol violation: pipe_req_valid dropped outside IDLE");

      if (l2_req_valid && l2_req_fulfilled) begin
        if (l2_req_type) wb++;
        else             ld++;
      end
      pw   += int'(perform_write);
      inst += int'(finish_new_line_install);
      addr += int'(set_new_l2_block_address);
      dtag += int'(set_new_l2_block_address && use_dirty_tag_for_l2_block_address);

      if (pipe_req_fulfilled) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected fulfil: got fulfil, expected no pending request");
        end else begin
          e = sb_q.pop_front();
          check("writeback words", wb, e.wb);
          check("allocate words", ld, e.ld);
          check("perform_write count", pw, e.pw);
          check("line installs", inst, e.inst);
          check("l2 address loads", addr, e.addr);
          check("dirty-tag address loads", dtag, e.dtag);
          check("fulfil perform_write", int'(perform_write), e.f_pw);
          check("fulfil set_dirty", int'(set_selected_dirty_bit), e.f_sd);
          check("fulfil clear_dirty", int'(clear_selected_dirty_bit), e.f_cd);
          check("fulfil clear_valid", int'(clear_selected_valid_bit), e.f_cv);
          pe   = e;
          pend = 1;
        end
        wb = 0; ld = 0; pw = 0; inst = 0; addr = 0; dtag = 0;
      end
      p_l2v = int'(l2_req_valid);
      p_l2f = int'(l2_req_fulfilled);
      p_l2t = int'(l2_req_type);
      p_ful = int'(pipe_req_fulfilled);
    end
  end

  initial begin
    int n;
    int r;
    reset          = 1'b1;
    pipe_req_valid = 1'b0;
    pipe_req_type  = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("in reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // directed: cold load, store hit, dirty-victim load, dirty flush,
    // flush miss, reserved type
    issue(0, 1);
    issue(1, 1);
    issue(0, 2);
    issue(1, 2);
    issue(2, 2);
    issue(2, 2);
    issue(3, 0);

    // reset during the 4th allocate word
    @(posedge clk);
    #1;
    req_tag        = 3;
    pipe_req_type  = 2'd0;
    pipe_req_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge clk);
      if (l2_req_valid && !l2_req_type && l2_req_fulfilled) n++;
    end
    check("allocate words before reset", n, 3);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    pipe_req_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset mid-allocate");
    sb_q.delete();
    ref_hit  = 0;
    ref_miss = 0;
    ref_v    = 0;
    ref_d    = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle after reset");
    issue(0, 3);

    // forced misses drive miss_count into saturation
    for (int i = 0; i < 18; i++) issue(0, i % 2);

    // randomized traffic with variable L2 latency
    rand_lat = 1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if      (r < 7)  issue(0, $urandom_range(0, 3));
      else if (r < 14) issue(1, $urandom_range(0, 3));
      else if (r < 18) issue(2, $urandom_range(0, 3));
      else             issue(3, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 pipe_req_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1 pipe_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    finish_run();
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter STAT_WIDTH, default 32, giving the width of the hit and miss statistics counters.
REQ-002 SHALL have input clk, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have input reset, 1 bit: synchronous, active-high.
REQ-004 SHALL have input pipe_req_valid, 1 bit: pipeline request present; address, size and type are held stable until fulfilled.
REQ-005 SHALL have input pipe_req_type, 2 bits: 0 LOAD, 1 STORE, 2 CLFLUSH, 3 reserved.
REQ-006 SHALL have output pipe_req_fulfilled, 1 bit: request completes this cycle.
REQ-007 SHALL have output l2_req_valid, 1 bit, and output l2_req_type, 1 bit (0 LOAD, 1 STORE): word request to L2.
REQ-008 SHALL have input l2_req_fulfilled, 1 bit: L2 has completed the current word this cycle.
REQ-009 SHALL have inputs counter_done, valid_block_match and valid_dirty_bit, 1 bit each, from the datapath.
REQ-010 SHALL have 1-bit outputs to the datapath: flush_mode, load_mode, clear_selected_dirty_bit, set_selected_dirty_bit, perform_write, clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address, use_dirty_tag_for_l2_block_address, reset_counter, decrement_counter.
REQ-011 SHALL have outputs hit_count and miss_count, STAT_WIDTH bits each.

Function
REQ-012 SHALL implement the states IDLE, WRITEBACK and ALLOCATE; all datapath outputs are 0 unless listed for the state and condition.
REQ-013 IDLE, LOAD hit (pipe_req_valid and valid_block_match): pipe_req_fulfilled=1 in the same cycle (zero-cycle hit); stay in IDLE.
REQ-014 IDLE, STORE hit: pipe_req_fulfilled=1, perform_write=1 and set_selected_dirty_bit=1 in the same cycle; stay in IDLE.
REQ-015 IDLE, LOAD/STORE miss with valid_dirty_bit=1: set_new_l2_block_address=1, use_dirty_tag_for_l2_block_address=1, reset_counter=1; next state WRITEBACK.
REQ-016 IDLE, LOAD/STORE miss with valid_dirty_bit=0: set_new_l2_block_address=1, use_dirty_tag_for_l2_block_address=0, reset_counter=1, clear_selected_valid_bit=1; next state ALLOCATE.
REQ-017 IDLE, CLFLUSH, not a hit: pipe_req_fulfilled=1; no other output.
REQ-018 IDLE, CLFLUSH, hit and clean: clear_selected_valid_bit=1 and pipe_req_fulfilled=1.
REQ-019 IDLE, CLFLUSH, hit and dirty: same outputs as REQ-015; next state WRITEBACK.
REQ-020 IDLE, type 3: pipe_req_fulfilled=1; no writes and no metadata change.
REQ-021 WRITEBACK: flush_mode=1, l2_req_valid=1, l2_req_type=STORE throughout; on l2_req_fulfilled with counter_done=0, decrement_counter=1.
REQ-022 WRITEBACK, l2_req_fulfilled with counter_done=1: clear_selected_dirty_bit=1, then:
- if CLFLUSH: clear_selected_valid_bit=1, pipe_req_fulfilled=1, next IDLE;
- otherwise: outputs of REQ-016, next ALLOCATE.
REQ-023 ALLOCATE: load_mode=1, l2_req_valid=1, l2_req_type=LOAD throughout; on l2_req_fulfilled, perform_write=1, plus decrement_counter=1 if counter_done=0.
REQ-024 ALLOCATE, l2_req_fulfilled with counter_done=1: finish_new_line_install=1; next IDLE. The held request then hits per REQ-013/014.
REQ-025 SHALL keep l2_req_valid stable and held until l2_req_fulfilled, with no timeout.
REQ-026 SHALL never assert set and clear of the same metadata bit together; flush_mode and load_mode are mutually exclusive.
REQ-027 hit_count SHALL increment once per LOAD/STORE fulfilled without passing through ALLOCATE; miss_count SHALL increment once per LOAD/STORE that leaves IDLE.
REQ-028 Both statistics counters SHALL saturate at all-ones; CLFLUSH and type 3 SHALL count in neither.
REQ-029 pipe_req_valid dropping outside IDLE SHALL be a protocol violation; the behaviour is unspecified and is flagged by a bench assertion.

Reset
REQ-030 Reset SHALL force IDLE, clear hit_count and miss_count, and drive every output to 0 in the reset cycle, including mid-WRITEBACK/ALLOCATE with no partial completion.
REQ-031 The first request after reset deasserts SHALL be evaluated in that cycle.

Verification
REQ-032 Cold LOAD to a line with valid=0, L2 answers each word after 2 cycles -> ALLOCATE with 8 perform_writes, finish_new_line_install, then hit fulfilled; miss_count=1, hit_count=0.
REQ-033 STORE hit -> fulfilled in the same cycle with perform_write=1 and set_selected_dirty_bit=1; hit_count increments by 1.
REQ-034 LOAD miss on a valid dirty line -> 8 L2 STORE words with flush_mode=1 and use_dirty_tag_for_l2_block_address=1 at entry, then 8 L2 LOAD words, then fulfilled.
REQ-035 CLFLUSH on a dirty hit -> WRITEBACK; the last word asserts clear_selected_dirty_bit, clear_selected_valid_bit and pipe_req_fulfilled together; neither counter changes.
REQ-036 reset asserted during the 4th ALLOCATE word -> next cycle IDLE, all outputs 0, counters 0; a reissued request restarts the miss from the beginning.
REQ-037 miss_count preloaded to all-ones via forced misses (STAT_WIDTH=4) -> 16th and later misses hold the value at 4'hF.
